pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-flow controller for the 9-bit single-cycle core: owns the program counter, start/done handshake with the testbench, branch-target selection and halt detection.
- Sits between instruction ROM and the control decoder: drives `pc` to the ROM and takes back the fetched `instr`, plus the decoder's `branch` (already zero-gated) and `how_high`.
- Adds a stall input for multi-cycle memory and a cycle-budget watchdog.

Parameters:
- PC_W, 10, program counter width; ROM depth 2^PC_W.
- MCODE_W, 9, instruction width.
- START_PC, 0, PC loaded on each start.
- HALT_CODE, 9'b111_0_11_111, reserved encoding (branch class, how_high=3, low bits 111) meaning halt.
- MAX_CYCLES, 16'hFFFF, watchdog budget in RUN cycles.
- T0/T1/T2/T3, 0/0/0/0, absolute branch targets selected by how_high 0..3 (PC_W bits each).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- req  in  1  start request; level or pulse, sampled in IDLE/DONE only.
- instr  in  MCODE_W  instruction currently addressed by pc.
- branch  in  1  decoder branch-taken (already ~zero gated).
- how_high  in  2  branch-target LUT index.
- stall  in  1  freeze request from data memory; holds pc.
- pc  out  PC_W  program counter to instruction ROM.
- running  out  1  high while state==RUN.
- done  out  1  high while state==DONE.
- timeout  out  1  sticky; set when the watchdog ended the run.
- cycle_cnt  out  16  RUN cycles elapsed in current or last run.

Behaviour:
- Reset (synchronous, any state, mid-run included): state=IDLE, pc=START_PC, running=0, done=0, timeout=0, cycle_cnt=0. No partial update survives.
- States: IDLE, RUN, DONE. Encoding: 2 bits. running/done decode from registered state only; no combinational path from inputs to them.
- IDLE:
  - req=1 → RUN next cycle; pc=START_PC, cycle_cnt=0, timeout=0.
  - req=0 → stay; all outputs hold.
- RUN, every cycle, first in priority order:
  1. cycle_cnt==MAX_CYCLES-1 → DONE, timeout=1, pc holds.
  2. stall=1 → pc holds, halt and branch ignored this cycle.
  3. instr==HALT_CODE → DONE, pc holds at the halt address, timeout=0.
  4. branch=1 → pc=T[how_high].
  5. else pc=pc+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
- RUN counter: cycle_cnt increments by 1 on every RUN cycle, stalled ones included. It saturates at 16'hFFFF, which is unreachable unless MAX_CYCLES=0.
- RUN start request: req is ignored.
- Latency: a next-PC decision is one cycle. pc changes on the edge after instr/branch are presented; first fetch address is valid the cycle RUN is entered.
- DONE:
  - done=1; pc, cycle_cnt and timeout hold.
  - req=1 → RUN, with the same reload as from IDLE; done drops the following cycle.
- Simultaneous events:
  - halt+branch → halt wins.
  - stall+halt → stall wins; halt is recognized when stall drops with instr unchanged.
  - watchdog+anything → watchdog wins.
  - reset+req → reset wins.
- Branch to own address (T==pc) is legal and loops until the watchdog fires.

Decomposition:
- Shared package (proc_pkg): state enum {IDLE, RUN, DONE}, HALT_CODE constant, PC_W/MCODE_W defaults. The decoder imports the same HALT_CODE.
- Sub-module branch_lut: combinational 4-entry parameterised target table, how_high → target.
- The sequencer FSM, pc register and counter stay in pc_sequencer.

Test Plan:
- Reset/start: reset 2 cycles, req pulse → running=1 next cycle, pc=0, then 1,2,3 on successive cycles with NOP instr; done=0.
- Branch: T2=10'h040, at pc=5 drive branch=1, how_high=2 → pc=0x040 next cycle. branch=1 with halt instr at the same pc → done=1, pc stays at halt address.
- Stall: stall high 3 cycles at pc=7 → pc stays 7, cycle_cnt advances by 3. HALT_CODE present during stall is not taken until stall=0.
- Wrap: PC_W=4, run 16 NOPs from 0 → pc 15 then 0, no state change.
- Watchdog: MAX_CYCLES=20, T0=pc loop (branch to self) → after 20 RUN cycles done=1, timeout=1, cycle_cnt=19. req in DONE → restart with timeout=0, cycle_cnt=0.
- Reset mid-run: assert reset at cycle 5 of RUN → next edge state IDLE, pc=START_PC, all flags 0. req during the reset cycle is ignored.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit core: sequencer state, default widths
// and the reserved halt encoding that the control decoder also imports.
package proc_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int MCODE_W_DEF = 9;

  // Branch class, how_high=3, low bits 111: never a real branch.
  localparam logic [MCODE_W_DEF-1:0] HALT_CODE = 9'b111_0_11_111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_lut.sv
// Four-entry absolute branch-target table indexed by the decoder's how_high.
module branch_lut #(
  parameter int              PC_W = proc_pkg::PC_W_DEF,
  parameter logic [PC_W-1:0] T0   = '0,
  parameter logic [PC_W-1:0] T1   = '0,
  parameter logic [PC_W-1:0] T2   = '0,
  parameter logic [PC_W-1:0] T3   = '0
) (
  input  logic [1:0]      how_high,
  output logic [PC_W-1:0] target
);

  // Pure table lookup from how_high to its target address.
  always_comb begin
    // NOTE: default assignment first so no path can leave target unassigned
    // and infer a latch.
    target = T0;
    unique case (how_high)
      2'd0: target = T0;
      2'd1: target = T1;
      2'd2: target = T2;
      2'd3: target = T3;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC, the start/done handshake, branch
// target selection, halt detection, a stall hold and a RUN-cycle watchdog.
module pc_sequencer
  import proc_pkg::*;
#(
  parameter int                 PC_W       = PC_W_DEF,
  parameter int                 MCODE_W    = MCODE_W_DEF,
  parameter logic [PC_W-1:0]    START_PC   = '0,
  parameter logic [MCODE_W-1:0] HALT_CODE  = MCODE_W'(proc_pkg::HALT_CODE),
  parameter logic [15:0]        MAX_CYCLES = 16'hFFFF,
  parameter logic [PC_W-1:0]    T0         = '0,
  parameter logic [PC_W-1:0]    T1         = '0,
  parameter logic [PC_W-1:0]    T2         = '0,
  parameter logic [PC_W-1:0]    T3         = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [MCODE_W-1:0] instr,
  input  logic               branch,
  input  logic [1:0]         how_high,
  input  logic               stall,
  output logic [PC_W-1:0]    pc,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [15:0]        cycle_cnt
);

  // Count value on the last permitted RUN cycle; MAX_CYCLES=0 wraps to
  // 16'hFFFF, the only case in which the counter can saturate.
  localparam logic [15:0] WD_LAST = MAX_CYCLES - 16'd1;

  state_t            state;
  logic [PC_W-1:0]   target;
  logic              wd_fire;
  logic              is_halt;
  logic [15:0]       cnt_inc;

  branch_lut #(
    .PC_W (PC_W),
    .T0   (T0),
    .T1   (T1),
    .T2   (T2),
    .T3   (T3)
  ) u_branch_lut (
    .how_high (how_high),
    .target   (target)
  );

  assign wd_fire = (cycle_cnt == WD_LAST);
  assign is_halt = (instr == HALT_CODE);
  assign cnt_inc = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;

  // Status flags decode straight from the state register.
  assign running = (state == RUN);
  assign done    = (state == DONE);

  // Sequencer FSM, PC register, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments for every register so all state
      // updates land together at the edge regardless of statement order.
      state     <= IDLE;
      pc        <= START_PC;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (req) begin
            state     <= RUN;
            pc        <= START_PC;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
          end
        end
        RUN: begin
          if (wd_fire) begin
            state   <= DONE;
            timeout <= 1'b1;
          end else begin
            cycle_cnt <= cnt_inc;
            // A stalled cycle holds pc and defers halt/branch decisions.
            if (!stall) begin
              if (is_halt) begin
                state <= DONE;
              end else if (branch) begin
                pc <= target;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
